// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Sequencer for the instruction-fetch datapath. After reset it holds the PC
// at RESET_PC for a fixed boot delay. It then either accepts a program from
// an external loader into instruction memory (LOAD) or goes straight to
// fetching (RUN). Fetch stops on a debug halt request or when the halt
// instruction word is seen, and restarts on a debug resume. The PC adder,
// sign-extend and branch mux stay in the datapath. This block only drives
// the PC-register enables and the instruction-memory port controls.
//
// Ports
//   clk            system clock, rising edge
//   start_up_n     asynchronous active-low reset
//   load_en        sampled on the last IDLE cycle: 1 = LOAD, 0 = RUN
//   ld_valid       loader word valid
//   ld_ready       controller accepts loader words (LOAD and HALT)
//   ld_addr        loader byte address, expected word aligned
//   ld_data        loader data word
//   ld_last        final loader word (acted on in LOAD only)
//   instr          instruction read from memory at the current PC
//   branch_taken   branch decision from decode
//   dbg_halt_req   debug halt request (level)
//   dbg_resume     debug resume request (level)
//   pc_init        PC register loads RESET_PC
//   pc_en          PC register loads the next PC
//   npc_sel        branch select to the fetch mux, gated to RUN
//   mem_sel        memory address source: 0 = PC, 1 = loader
//   mem_we         instruction-memory write strobe
//   mem_addr       loader address passthrough
//   mem_din        loader data passthrough
//   fetch_valid    instr holds a valid fetched instruction this cycle
//   halted         controller is in HALT
//   halt_cause     00 none, 01 debug request, 10 halt word
//   ld_err         sticky flag: a misaligned loader write was dropped
//   fetch_count    instructions fetched in RUN, saturating
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0020,
    parameter int unsigned BOOT_DELAY = 4,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        start_up_n,
    input  logic        load_en,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        dbg_halt_req,
    input  logic        dbg_resume,
    output logic        pc_init,
    output logic        pc_en,
    output logic        npc_sel,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        fetch_valid,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic        ld_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_e;

    localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_DEBUG = 2'b01;
    localparam logic [1:0] CAUSE_WORD  = 2'b10;

    state_e            state_q;
    logic [CNT_W-1:0]  bootCnt_q;
    logic [1:0]        haltCause_q;
    logic              skip_q;
    logic              ldErr_q;
    logic              ldErr_d;
    logic [31:0]       fetchCount_q;
    logic [31:0]       fetchCount_d;

    logic isIdle;
    logic isLoad;
    logic isRun;
    logic isHalt;
    logic ldAccept;
    logic ldAligned;
    logic haltWordHit;

    // State decodes shared by the output logic and the sequencer below.
    assign isIdle = (state_q == IDLE);
    assign isLoad = (state_q == LOAD);
    assign isRun  = (state_q == RUN);
    assign isHalt = (state_q == HALT);

    // The loader port is open in LOAD and in HALT, so a debugger can patch
    // memory while fetch is stopped. The memory controls follow the loader
    // inputs in the same cycle so the write lands on this clock edge. A
    // misaligned address still counts as an accept, but its write is dropped.
    assign ld_ready  = isLoad | isHalt;
    assign ldAccept  = ld_valid & ld_ready;
    assign ldAligned = (ld_addr[1:0] == 2'b00);
    assign mem_sel   = ldAccept;
    assign mem_we    = ldAccept & ldAligned;
    assign mem_addr  = ldAccept ? ld_addr : 32'h0;
    assign mem_din   = ldAccept ? ld_data : 32'h0;

    // Halt-word detection is masked for one RUN cycle after a resume from a
    // halt-word stop. Without this mask the PC could never step past the
    // halt word it is parked on.
    assign haltWordHit = isRun & (instr == HALT_WORD) & ~skip_q;

    // The PC is pinned to the boot address until fetch starts. On a
    // halt-word hit the PC must not advance, so the halt word stays at the
    // PC for the resume step.
    assign pc_init     = isIdle | isLoad;
    assign pc_en       = isRun & ~haltWordHit;
    assign fetch_valid = isRun;
    assign npc_sel     = isRun & branch_taken;
    assign halted      = isHalt;
    assign halt_cause  = haltCause_q;
    assign ld_err      = ldErr_q;
    assign fetch_count = fetchCount_q;

    // Next values for the fetch counter and the sticky loader error. The
    // halt-word fetch is not counted, and the counter holds at all-ones
    // rather than wrapping.
    always_comb begin
        fetchCount_d = fetchCount_q;
        if (isRun && !haltWordHit && (fetchCount_q != 32'hFFFF_FFFF)) begin
            fetchCount_d = fetchCount_q + 32'd1;
        end
        ldErr_d = ldErr_q | (ldAccept & ~ldAligned);
    end

    // Main sequencer. IDLE runs the boot delay and then picks LOAD or RUN
    // from load_en. LOAD waits for the last loader word. In RUN a halt word
    // takes priority over a debug request. A debug request lets its own
    // cycle fetch normally, and only then enters HALT. HALT ignores resume
    // while the halt request is still asserted.
    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            state_q      <= IDLE;
            bootCnt_q    <= '0;
            haltCause_q  <= CAUSE_NONE;
            skip_q       <= 1'b0;
            ldErr_q      <= 1'b0;
            fetchCount_q <= 32'h0;
        end else begin
            fetchCount_q <= fetchCount_d;
            ldErr_q      <= ldErr_d;
            case (state_q)
                IDLE: begin
                    bootCnt_q <= bootCnt_q + CNT_W'(1);
                    if (bootCnt_q == BOOT_LAST) begin
                        state_q <= load_en ? LOAD : RUN;
                    end
                end
                LOAD: begin
                    if (ldAccept && ld_last) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    skip_q <= 1'b0;
                    if (haltWordHit) begin
                        haltCause_q <= CAUSE_WORD;
                        state_q     <= HALT;
                    end else if (dbg_halt_req) begin
                        haltCause_q <= CAUSE_DEBUG;
                        state_q     <= HALT;
                    end
                end
                HALT: begin
                    if (dbg_resume && !dbg_halt_req) begin
                        state_q     <= RUN;
                        haltCause_q <= CAUSE_NONE;
                        skip_q      <= (haltCause_q == CAUSE_WORD);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//
// Test bench for fetch_controller. The bench provides a small fetch
// datapath: a PC register driven by pc_init, pc_en and npc_sel, and a
// 64-word instruction memory written through mem_we, mem_addr and mem_din.
// instr is read from that memory at the PC. Each table row is one clock
// cycle. It holds the inputs and the outputs required in that cycle. The
// required outputs are the controller flags, the PC, the fetched word and
// the fetch count. Rows are queued as they are driven, then popped and
// compared once the outputs have settled. Asynchronous reset in the middle
// of RUN and LOAD is checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    localparam logic [31:0] PC0      = 32'h0040_0020;
    localparam logic [31:0] HW       = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] MEM_BASE = 32'h0040_0000;
    localparam logic [31:0] BR_OFF   = 32'h0000_0010;
    localparam logic [10:0] CTL_RST  = 11'b1000_000_0_00_0;

    logic        clk;
    logic        start_up_n;
    logic        load_en;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [31:0] instr;
    logic        branch_taken;
    logic        dbg_halt_req;
    logic        dbg_resume;
    logic        pc_init;
    logic        pc_en;
    logic        npc_sel;
    logic        mem_sel;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        fetch_valid;
    logic        halted;
    logic [1:0]  halt_cause;
    logic        ld_err;
    logic [31:0] fetch_count;

    logic [31:0] pcModel;
    logic [31:0] imem [0:63];
    logic        tbClear;
    logic [10:0] obs;

    int checks;
    int errors;

    // One table row per cycle. The bits of ctl are, from msb to lsb:
    // pc_init, pc_en, fetch_valid, halted, ld_ready, mem_sel, mem_we,
    // npc_sel, halt_cause[1:0], ld_err.
    typedef struct {
        string       tag;
        logic        le;
        logic        lv;
        logic        ll;
        logic        br;
        logic        hr;
        logic        rs;
        logic [31:0] la;
        logic [31:0] ldat;
        logic [10:0] ctl;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];

    fetch_controller dut (
        .clk          (clk),
        .start_up_n   (start_up_n),
        .load_en      (load_en),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .instr        (instr),
        .branch_taken (branch_taken),
        .dbg_halt_req (dbg_halt_req),
        .dbg_resume   (dbg_resume),
        .pc_init      (pc_init),
        .pc_en        (pc_en),
        .npc_sel      (npc_sel),
        .mem_sel      (mem_sel),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .ld_err       (ld_err),
        .fetch_count  (fetch_count)
    );

    // Free-running clock with a 10-unit period. Rising edges fall at 5, 15, 25 and so on.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {pc_init, pc_en, fetch_valid, halted, ld_ready,
                  mem_sel, mem_we, npc_sel, halt_cause, ld_err};

    function automatic logic [5:0] wordIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - MEM_BASE;
        return off[7:2];
    endfunction

    // The datapath PC register. Branches jump 16 bytes ahead so that a taken
    // branch is easy to see in the PC trace.
    always @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            pcModel <= PC0;
        end else if (pc_init) begin
            pcModel <= PC0;
        end else if (pc_en) begin
            pcModel <= npc_sel ? pcModel + BR_OFF : pcModel + 32'd4;
        end
    end

    // The instruction memory. The bench fills it with NOPs during reset.
    // After that, only the controller's write strobe changes it.
    always @(posedge clk) begin
        if (tbClear) begin
            for (int i = 0; i < 64; i++) begin
                imem[i] <= NOP;
            end
        end else if (mem_we) begin
            imem[wordIdx(mem_addr)] <= mem_din;
        end
    end

    assign instr = imem[wordIdx(pcModel)];

    // Safety net in case the run stops advancing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input string tag, input logic le, input logic lv,
                          input logic ll, input logic br, input logic hr,
                          input logic rs, input logic [31:0] la,
                          input logic [31:0] ldat, input logic [10:0] ctl,
                          input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] cnt);
        vec_t v;
        v.tag = tag; v.le = le; v.lv = lv; v.ll = ll; v.br = br;
        v.hr = hr; v.rs = rs; v.la = la; v.ldat = ldat; v.ctl = ctl;
        v.pc = pc; v.ins = ins; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        load_en      = v.le;
        ld_valid     = v.lv;
        ld_last      = v.ll;
        branch_taken = v.br;
        dbg_halt_req = v.hr;
        dbg_resume   = v.rs;
        ld_addr      = v.la;
        ld_data      = v.ldat;
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        #1;
        if (expQ.size() == 0) begin
            compare("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            compare({e.tag, ".ctl"},   {21'h0, obs}, {21'h0, e.ctl});
            compare({e.tag, ".pc"},    pcModel,      e.pc);
            compare({e.tag, ".instr"}, instr,        e.ins);
            compare({e.tag, ".count"}, fetch_count,  e.cnt);
        end
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end
    endtask

    task automatic doReset();
        start_up_n   = 1'b0;
        load_en      = 1'b0;
        ld_valid     = 1'b0;
        ld_last      = 1'b0;
        branch_taken = 1'b0;
        dbg_halt_req = 1'b0;
        dbg_resume   = 1'b0;
        ld_addr      = 32'h0;
        ld_data      = 32'h0;
        tbClear      = 1'b1;
        repeat (2) @(posedge clk);
        #1 tbClear = 1'b0;
        #1 start_up_n = 1'b1;
    endtask

    // Drop reset between clock edges while the current row's inputs are
    // still applied. Every output must go back to its reset value at once.
    task automatic midReset(input string tag);
        #1 start_up_n = 1'b0;
        #1;
        compare({tag, ".ctl"},   {21'h0, obs}, {21'h0, CTL_RST});
        compare({tag, ".count"}, fetch_count,  32'h0);
        compare({tag, ".pc"},    pcModel,      PC0);
    endtask

    initial begin
        int aEnd;
        int bEnd;
        int cLoadEnd;
        int cEnd;

        checks     = 0;
        errors     = 0;
        start_up_n = 1'b0;
        tbClear    = 1'b1;

        // Phase A: boot with no program load, fetch with a branch, debug
        // halt, and a resume while the halt request is held.
        addVec("a_idle0", 0,1,0,0,0,0, PC0, 32'hAAAA_0000, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("a_idle1", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("a_idle2", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("a_idle3", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("a_run0",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_0020, NOP, 0);
        addVec("a_run1",  0,1,0,0,0,0, 32'h0040_0040, 32'hBADB_AD00, 11'b0110_000_0_00_0, 32'h0040_0024, NOP, 1);
        addVec("a_run2",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_0028, NOP, 2);
        addVec("a_run3",  0,0,0,1,0,0, 0, 0, 11'b0110_000_1_00_0, 32'h0040_002C, NOP, 3);
        addVec("a_run4",  0,0,0,0,1,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_003C, NOP, 4);
        addVec("a_halt0", 0,0,0,0,0,0, 0, 0, 11'b0001_100_0_01_0, 32'h0040_0040, NOP, 5);
        addVec("a_halt1", 0,0,0,1,1,1, 0, 0, 11'b0001_100_0_01_0, 32'h0040_0040, NOP, 5);
        addVec("a_halt2", 0,0,0,0,0,1, 0, 0, 11'b0001_100_0_01_0, 32'h0040_0040, NOP, 5);
        addVec("a_run5",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_0040, NOP, 5);
        addVec("a_run6",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_0044, NOP, 6);
        aEnd = vecs.size();

        // Phase B: load a program that includes a dropped misaligned word and
        // a halt word. Then run, stop on the halt word, patch memory from
        // HALT, and resume past the halt word.
        addVec("b_idle0", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("b_idle1", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("b_idle2", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("b_idle3", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("b_load0", 0,1,0,0,0,0, 32'h0040_0020, 32'h1111_1111, 11'b1000_111_0_00_0, PC0, NOP, 0);
        addVec("b_load1", 0,1,0,0,0,0, 32'h0040_0024, 32'h2222_2222, 11'b1000_111_0_00_0, PC0, 32'h1111_1111, 0);
        addVec("b_load2", 0,1,0,0,0,0, 32'h0040_0022, 32'h0000_DEAD, 11'b1000_110_0_00_0, PC0, 32'h1111_1111, 0);
        addVec("b_load3", 0,0,0,0,0,0, 0, 0, 11'b1000_100_0_00_1, PC0, 32'h1111_1111, 0);
        addVec("b_load4", 0,1,1,0,0,0, 32'h0040_0028, HW, 11'b1000_111_0_00_1, PC0, 32'h1111_1111, 0);
        addVec("b_run0",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_1, 32'h0040_0020, 32'h1111_1111, 0);
        addVec("b_run1",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_1, 32'h0040_0024, 32'h2222_2222, 1);
        addVec("b_run2",  0,0,0,0,1,0, 0, 0, 11'b0010_000_0_00_1, 32'h0040_0028, HW, 2);
        addVec("b_halt0", 0,0,0,0,0,0, 0, 0, 11'b0001_100_0_10_1, 32'h0040_0028, HW, 2);
        addVec("b_halt1", 0,1,1,0,0,0, 32'h0040_0030, 32'h3333_3333, 11'b0001_111_0_10_1, 32'h0040_0028, HW, 2);
        addVec("b_halt2", 0,0,0,0,0,1, 0, 0, 11'b0001_100_0_10_1, 32'h0040_0028, HW, 2);
        addVec("b_run3",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_1, 32'h0040_0028, HW, 2);
        addVec("b_run4",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_1, 32'h0040_002C, NOP, 3);
        addVec("b_run5",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_1, 32'h0040_0030, 32'h3333_3333, 4);
        bEnd = vecs.size();

        // Phase C: enter LOAD and set ld_err, then reset during an accept.
        // After reset the full boot delay must run again.
        addVec("c_idle0", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_idle1", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_idle2", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_idle3", 1,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_load0", 0,1,0,0,0,0, 32'h0040_0026, 32'h0000_5555, 11'b1000_110_0_00_0, PC0, NOP, 0);
        addVec("c_load1", 0,1,0,0,0,0, 32'h0040_0020, 32'h6666_6666, 11'b1000_111_0_00_1, PC0, NOP, 0);
        cLoadEnd = vecs.size();
        addVec("c_idle4", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_idle5", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_idle6", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_idle7", 0,0,0,0,0,0, 0, 0, 11'b1000_000_0_00_0, PC0, NOP, 0);
        addVec("c_run0",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_0020, NOP, 0);
        addVec("c_run1",  0,0,0,0,0,0, 0, 0, 11'b0110_000_0_00_0, 32'h0040_0024, NOP, 1);
        cEnd = vecs.size();

        doReset();
        runVectors(0, aEnd);
        midReset("a_async_reset_run");

        doReset();
        runVectors(aEnd, bEnd);

        doReset();
        runVectors(bEnd, cLoadEnd);
        midReset("c_async_reset_load");
        doReset();
        runVectors(cLoadEnd, cEnd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
